// File: rtl/bp_be_stride_prefetch_engine.sv
// Multi-degree stride prefetcher for the BE memory pipe.
// A direct-mapped reference prediction table is trained on committed memory
// ops with the Chen-Baer INIT/TRANSIENT/STEADY/NO_PRED scheme. A STEADY hit
// with a non-zero stride launches an issue session that walks degree_p
// candidates, filters those that fall in an already-covered cache block, and
// presents the rest one at a time on a registered valid/ready port.
module bp_be_stride_prefetch_engine #(
  parameter int vaddr_width_p  = 39,
  parameter int rpt_sets_p     = 32,
  parameter int stride_width_p = 12,
  parameter int degree_p       = 2,
  parameter int block_width_p  = 6,
  parameter int train_stores_p = 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     mem_v_i,
  input  logic                     mem_store_i,
  input  logic [vaddr_width_p-1:0] mem_pc_i,
  input  logic [vaddr_width_p-1:0] mem_addr_i,
  input  logic                     flush_i,
  output logic                     pf_v_o,
  output logic [vaddr_width_p-1:0] pf_addr_o,
  output logic [vaddr_width_p-1:0] pf_pc_o,
  input  logic                     pf_ready_i,
  output logic                     busy_o,
  output logic                     drop_o
);

  localparam int LG_SETS = $clog2(rpt_sets_p);
  localparam int TAG_W   = vaddr_width_p - 1 - LG_SETS;
  localparam int SW      = stride_width_p;
  localparam int HI_W    = vaddr_width_p - SW + 1;
  localparam int BLK_W   = vaddr_width_p - block_width_p;
  localparam int K_W     = $clog2(degree_p + 2);
  localparam logic [K_W-1:0] DEG_K = K_W'(degree_p);
  localparam logic TRAIN_ST = (train_stores_p != 0);

  typedef enum logic [1:0] {
    RPT_INIT      = 2'd0,
    RPT_TRANSIENT = 2'd1,
    RPT_STEADY    = 2'd2,
    RPT_NO_PRED   = 2'd3
  } rpt_state_e;

  typedef enum logic {
    FSM_IDLE  = 1'b0,
    FSM_ISSUE = 1'b1
  } fsm_e;

  // ---------------------------------------------------------------------------
  // Reference prediction table
  // ---------------------------------------------------------------------------
  logic [rpt_sets_p-1:0] r_valid;
  logic [TAG_W-1:0]      r_tag    [rpt_sets_p];
  rpt_state_e            r_state  [rpt_sets_p];
  logic [vaddr_width_p-1:0] r_last [rpt_sets_p];
  logic [SW-1:0]         r_stride [rpt_sets_p];

  logic [LG_SETS-1:0]       w_idx;
  logic [TAG_W-1:0]         w_tag;
  logic                     w_train;
  logic                     w_hit;
  rpt_state_e               w_old_state;
  logic [SW-1:0]            w_old_stride;
  logic [vaddr_width_p-1:0] w_old_stride_x;
  logic [vaddr_width_p-1:0] w_delta;
  logic [HI_W-1:0]          w_delta_hi;
  logic                     w_repr;
  logic [SW-1:0]            w_delta_s;
  logic                     w_correct;
  rpt_state_e               w_new_state;
  logic [SW-1:0]            w_new_stride;
  logic                     w_trigger;
  logic                     w_unused_pc0;

  // PC bit 0 carries no information for aligned instructions; it is neither index nor tag.
  assign w_unused_pc0 = mem_pc_i[0];

  assign w_idx   = mem_pc_i[1 +: LG_SETS];
  assign w_tag   = mem_pc_i[vaddr_width_p-1 : 1+LG_SETS];
  assign w_train = mem_v_i & (~mem_store_i | TRAIN_ST) & ~flush_i;

  assign w_hit          = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_old_state    = r_state[w_idx];
  assign w_old_stride   = r_stride[w_idx];
  assign w_old_stride_x = {{(vaddr_width_p-SW){w_old_stride[SW-1]}}, w_old_stride};

  // The delta fits the stride field only if its upper bits are a pure sign extension.
  assign w_delta    = mem_addr_i - r_last[w_idx];
  assign w_delta_hi = w_delta[vaddr_width_p-1 : SW-1];
  assign w_repr     = (w_delta_hi == '0) || (w_delta_hi == '1);
  assign w_delta_s  = w_repr ? w_delta[SW-1:0] : '0;
  assign w_correct  = w_repr && (w_delta[SW-1:0] == w_old_stride);

  // Chen-Baer state/stride update for the indexed entry.
  always_comb begin
    w_new_state  = RPT_INIT;
    w_new_stride = '0;
    if (w_hit) begin
      case (w_old_state)
        RPT_INIT: begin
          if (w_correct) begin
            w_new_state  = RPT_STEADY;
            w_new_stride = w_old_stride;
          end else begin
            w_new_state  = RPT_TRANSIENT;
            w_new_stride = w_delta_s;
          end
        end
        RPT_TRANSIENT: begin
          if (w_correct) begin
            w_new_state  = RPT_STEADY;
            w_new_stride = w_old_stride;
          end else begin
            w_new_state  = RPT_NO_PRED;
            w_new_stride = w_delta_s;
          end
        end
        RPT_STEADY: begin
          w_new_stride = w_old_stride;
          w_new_state  = w_correct ? RPT_STEADY : RPT_INIT;
        end
        default: begin
          if (w_correct) begin
            w_new_state  = RPT_TRANSIENT;
            w_new_stride = w_old_stride;
          end else begin
            w_new_state  = RPT_NO_PRED;
            w_new_stride = w_delta_s;
          end
        end
      endcase
    end
  end

  assign w_trigger = w_train & w_hit & w_correct & (w_new_state == RPT_STEADY) &
                     (w_old_stride != '0);

  // Valid bits: cleared by reset and flush, set on every trained op.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_valid <= '0;
    end else if (flush_i) begin
      r_valid <= '0;
    end else if (w_train) begin
      r_valid[w_idx] <= 1'b1;
    end
  end

  // Entry payload; a miss overwrites with INIT/stride 0 via the update logic.
  always_ff @(posedge clk_i) begin
    if (w_train) begin
      r_tag[w_idx]    <= w_tag;
      r_state[w_idx]  <= w_new_state;
      r_last[w_idx]   <= mem_addr_i;
      r_stride[w_idx] <= w_new_stride;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue FSM
  // ---------------------------------------------------------------------------
  fsm_e                     r_fsm,        w_fsm_next;
  logic [BLK_W-1:0]         r_base_blk,   w_base_blk_next;
  logic [vaddr_width_p-1:0] r_stride_x,   w_stride_x_next;
  logic [vaddr_width_p-1:0] r_cand,       w_cand_next;
  logic [vaddr_width_p-1:0] r_pc,         w_pc_next;
  logic [K_W-1:0]           r_k,          w_k_next;
  logic                     r_last_blk_v, w_last_blk_v_next;
  logic [BLK_W-1:0]         r_last_blk,   w_last_blk_next;
  logic                     r_pf_v,       w_pf_v_next;
  logic [vaddr_width_p-1:0] r_pf_addr,    w_pf_addr_next;
  logic                     r_drop,       w_drop_next;

  logic [BLK_W-1:0] w_cand_blk;
  logic             w_suppress;

  assign w_cand_blk = r_cand[vaddr_width_p-1 : block_width_p];
  assign w_suppress = (w_cand_blk == r_base_blk) ||
                      (r_last_blk_v && (w_cand_blk == r_last_blk));

  // Issue state registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_fsm        <= FSM_IDLE;
      r_base_blk   <= '0;
      r_stride_x   <= '0;
      r_cand       <= '0;
      r_pc         <= '0;
      r_k          <= '0;
      r_last_blk_v <= 1'b0;
      r_last_blk   <= '0;
      r_pf_v       <= 1'b0;
      r_pf_addr    <= '0;
      r_drop       <= 1'b0;
    end else begin
      r_fsm        <= w_fsm_next;
      r_base_blk   <= w_base_blk_next;
      r_stride_x   <= w_stride_x_next;
      r_cand       <= w_cand_next;
      r_pc         <= w_pc_next;
      r_k          <= w_k_next;
      r_last_blk_v <= w_last_blk_v_next;
      r_last_blk   <= w_last_blk_next;
      r_pf_v       <= w_pf_v_next;
      r_pf_addr    <= w_pf_addr_next;
      r_drop       <= w_drop_next;
    end
  end

  // Next-state: latch a trigger when idle, otherwise walk candidates one per free slot.
  always_comb begin
    w_fsm_next        = r_fsm;
    w_base_blk_next   = r_base_blk;
    w_stride_x_next   = r_stride_x;
    w_cand_next       = r_cand;
    w_pc_next         = r_pc;
    w_k_next          = r_k;
    w_last_blk_v_next = r_last_blk_v;
    w_last_blk_next   = r_last_blk;
    w_pf_v_next       = r_pf_v;
    w_pf_addr_next    = r_pf_addr;
    w_drop_next       = 1'b0;
    case (r_fsm)
      FSM_IDLE: begin
        if (w_trigger) begin
          w_fsm_next        = FSM_ISSUE;
          w_base_blk_next   = mem_addr_i[vaddr_width_p-1 : block_width_p];
          w_stride_x_next   = w_old_stride_x;
          w_cand_next       = mem_addr_i + w_old_stride_x;
          w_pc_next         = mem_pc_i;
          w_k_next          = K_W'(1);
          w_last_blk_v_next = 1'b0;
        end
      end
      default: begin
        w_drop_next = w_trigger;
        // The output slot is free when nothing is presented or it is taken this cycle.
        if (~r_pf_v | pf_ready_i) begin
          if (r_k > DEG_K) begin
            w_fsm_next  = FSM_IDLE;
            w_pf_v_next = 1'b0;
          end else begin
            w_k_next    = r_k + K_W'(1);
            w_cand_next = r_cand + r_stride_x;
            if (w_suppress) begin
              w_pf_v_next = 1'b0;
              if (r_k == DEG_K) begin
                w_fsm_next = FSM_IDLE;
              end
            end else begin
              w_pf_v_next       = 1'b1;
              w_pf_addr_next    = {w_cand_blk, {block_width_p{1'b0}}};
              w_last_blk_v_next = 1'b1;
              w_last_blk_next   = w_cand_blk;
            end
          end
        end
      end
    endcase
    if (flush_i) begin
      w_fsm_next  = FSM_IDLE;
      w_pf_v_next = 1'b0;
    end
  end

  assign pf_v_o    = r_pf_v;
  assign pf_addr_o = r_pf_addr;
  assign pf_pc_o   = r_pc;
  assign busy_o    = (r_fsm != FSM_IDLE);
  assign drop_o    = r_drop;

endmodule
